// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-buffer access sequencer.
// Holds the FSM state enum and the MBR control-vector bit positions.
package mem_ctrl_pkg;

   localparam int unsigned CTRL_W = 25;
   localparam int unsigned CNT_W  = 3;

   localparam int unsigned CTRL_MBR_OUT    = 5;
   localparam int unsigned CTRL_MBR_LD_MEM = 7;
   localparam int unsigned CTRL_MBR_WR_MEM = 8;
   localparam int unsigned CTRL_MBR_LD_ACC = 9;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_CAPT,
      S_XFER,
      S_ACC,
      S_WR,
      S_COMMIT,
      S_DONE
   } state_e;

   // MBR control bits owned by each state; every other bit stays 0.
   function automatic logic [CTRL_W-1:0] ctrl_for(input state_e st);
      logic [CTRL_W-1:0] c;
      c = '0;
      case (st)
         S_CAPT:  c[CTRL_MBR_LD_MEM] = 1'b1;
         S_XFER:  c[CTRL_MBR_OUT]    = 1'b1;
         S_ACC:   c[CTRL_MBR_LD_ACC] = 1'b1;
         S_WR:    c[CTRL_MBR_WR_MEM] = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and execute requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise execute has fixed priority.
module mem_arb_pick
   import mem_ctrl_pkg::*;
(
   input  logic fetch_req_i,
   input  logic ex_req_i,
`ifdef MEM_ARB_RR_EN
   input  logic last_ex_i,
`endif
   output logic pick_ex_c
);

`ifdef MEM_ARB_RR_EN
   // On contention serve whichever side did not win last time.
   always_comb begin
      pick_ex_c = ex_req_i;
      if (fetch_req_i && ex_req_i) begin
         pick_ex_c = ~last_ex_i;
      end
   end
`else
   always_comb begin
      pick_ex_c = ex_req_i;
      if (fetch_req_i && !ex_req_i) begin
         pick_ex_c = 1'b0;
      end
   end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-buffer access sequencer: arbitrates fetch/execute and drives MAR, strobes, MBR control.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: execute priority).
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned MEM_LAT = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   input  logic              ex_req,
   input  logic              ex_we,
   input  logic [ADDR_W-1:0] ex_addr,
   output logic              ex_ack,
   output logic [ADDR_W-1:0] mar_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [CTRL_W-1:0] control,
   output logic              busy,
   output logic              gnt_ex
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam bit               HAS_WAIT = (MEM_LAT > 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   mar_q, mar_d;
   logic                mem_re_q, mem_re_d;
   logic                mem_we_q, mem_we_d;
   logic                fetch_ack_q, fetch_ack_d;
   logic                ex_ack_q, ex_ack_d;
   logic                busy_q, busy_d;
   logic [CTRL_W-1:0]   control_q, control_d;
   logic                pick_ex_c;

`ifdef MEM_ARB_RR_EN
   logic last_ex_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_ex_q <= 1'b0;
      end else if (state_q == S_DONE) begin
         last_ex_q <= owner_q;
      end
   end

   mem_arb_pick u_arb (
      .fetch_req_i (fetch_req),
      .ex_req_i    (ex_req),
      .last_ex_i   (last_ex_q),
      .pick_ex_c   (pick_ex_c)
   );
`else
   mem_arb_pick u_arb (
      .fetch_req_i (fetch_req),
      .ex_req_i    (ex_req),
      .pick_ex_c   (pick_ex_c)
   );
`endif

   // Next state, transaction latches, and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      mar_d   = mar_q;
      case (state_q)
         S_IDLE: begin
            if (fetch_req || ex_req) begin
               owner_d = pick_ex_c;
               mar_d   = pick_ex_c ? ex_addr : fetch_addr;
               state_d = (pick_ex_c && ex_we) ? S_ACC : S_ADDR;
            end
         end
         S_ADDR: begin
            cnt_d   = CNT_LOAD;
            state_d = HAS_WAIT ? S_WAIT : S_CAPT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_d == '0) begin
               state_d = S_CAPT;
            end
         end
         S_CAPT:   state_d = S_XFER;
         S_XFER:   state_d = S_DONE;
         S_ACC:    state_d = S_WR;
         S_WR:     state_d = S_COMMIT;
         S_COMMIT: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      mem_re_d    = (state_d == S_ADDR);
      mem_we_d    = (state_d == S_COMMIT);
      fetch_ack_d = (state_d == S_DONE) && !owner_d;
      ex_ack_d    = (state_d == S_DONE) &&  owner_d;
      busy_d      = (state_d != S_IDLE);
      control_d   = ctrl_for(state_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         owner_q     <= 1'b0;
         mar_q       <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         fetch_ack_q <= 1'b0;
         ex_ack_q    <= 1'b0;
         busy_q      <= 1'b0;
         control_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         mar_q       <= mar_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         fetch_ack_q <= fetch_ack_d;
         ex_ack_q    <= ex_ack_d;
         busy_q      <= busy_d;
         control_q   <= control_d;
      end
   end

   assign mar_addr  = mar_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign fetch_ack = fetch_ack_q;
   assign ex_ack    = ex_ack_q;
   assign busy      = busy_q;
   assign gnt_ex    = owner_q;
   assign control   = control_q;

endmodule
